imem_fetch_ctrl: RTL and testbench

//   Sequences the instruction memory for the fetch stage: drives its read enable and
//   PC, registers fetched words into the IF/ID pipeline register, and handles stall,

---
 rtl/imem_fetch_ctrl_pkg.sv | 15 +
 rtl/imem_fetch_ctrl.sv | 138 +++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared fetch-stage definitions: default widths, reset PC, NOP encoding and the
// fetch sequencer state enum.
package imem_fetch_ctrl_pkg;

    localparam int          XLEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP          = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory fetch sequencer: drives IMEM read/write ports, owns the PC and
// the IF/ID register, and handles stall, redirect, halt and program loading.
module imem_fetch_ctrl
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int               XLEN       = XLEN_DEF,
    parameter int               IMEM_DEPTH = 128,
    parameter logic [XLEN-1:0]  RESET_PC   = XLEN'(RESET_PC_DEF)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                halt,
    input  logic                stall,
    input  logic                redirect_en,
    input  logic [XLEN-1:0]     redirect_pc,
    output logic                imem_rd,
    output logic [XLEN-1:0]     imem_addr,
    input  logic [XLEN-1:0]     imem_rdata,
    output logic                imem_we,
    output logic [XLEN-1:0]     imem_waddr,
    output logic [XLEN-1:0]     imem_wdata,
    input  logic                ld_valid,
    output logic                ld_ready,
    input  logic [XLEN-1:0]     ld_addr,
    input  logic [XLEN-1:0]     ld_data,
    output logic                ifid_valid,
    output logic [XLEN-1:0]     ifid_pc,
    output logic [XLEN-1:0]     ifid_ir,
    output logic                err_misalign,
    output logic                err_oob,
    output fetch_state_t        dbg_state
);

    // Loader handshake: a word transfers on any cycle where ld_valid && ld_ready.
    localparam logic [XLEN-1:0] MEM_BYTES = XLEN'(IMEM_DEPTH * 4);
    localparam logic [XLEN-1:0] NOP_W     = XLEN'(NOP);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
    logic [XLEN-1:0] ifid_ir_q, ifid_ir_d;
    logic            ifid_valid_q, ifid_valid_d;
    logic            err_mis_q, err_mis_d;
    logic            err_oob_q, err_oob_d;

    logic pc_oob, ld_oob, redirect_misaligned;

    assign pc_oob              = (pc_q >= MEM_BYTES);
    assign ld_oob              = (ld_addr >= MEM_BYTES);
    assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            ifid_pc_q    <= '0;
            ifid_ir_q    <= NOP_W;
            ifid_valid_q <= 1'b0;
            err_mis_q    <= 1'b0;
            err_oob_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_ir_q    <= ifid_ir_d;
            ifid_valid_q <= ifid_valid_d;
            err_mis_q    <= err_mis_d;
            err_oob_q    <= err_oob_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_ir_d    = ifid_ir_q;
        ifid_valid_d = ifid_valid_q;
        err_mis_d    = err_mis_q;
        err_oob_d    = err_oob_q;
        imem_rd      = 1'b0;
        imem_we      = 1'b0;
        ld_ready     = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_HALT: begin
                ld_ready = !start;
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = RESET_PC;
                end else if (ld_valid) begin
                    // Out-of-range words are consumed so the loader never stalls.
                    if (ld_oob) err_oob_d = 1'b1;
                    else        imem_we   = 1'b1;
                end
            end
            ST_RUN: begin
                imem_rd = !pc_oob;
                if (halt) begin
                    state_d      = ST_HALT;
                    ifid_valid_d = 1'b0;
                    ifid_ir_d    = NOP_W;
                end else if (redirect_en && !redirect_misaligned) begin
                    pc_d         = redirect_pc;
                    ifid_valid_d = 1'b0;
                    ifid_ir_d    = NOP_W;
                end else if (redirect_en) begin
                    state_d      = ST_HALT;
                    err_mis_d    = 1'b1;
                    ifid_valid_d = 1'b0;
                    ifid_ir_d    = NOP_W;
                end else if (pc_oob) begin
                    state_d      = ST_HALT;
                    err_oob_d    = 1'b1;
                    ifid_valid_d = 1'b0;
                    ifid_ir_d    = NOP_W;
                end else if (!stall) begin
                    ifid_ir_d    = imem_rdata;
                    ifid_pc_d    = pc_q;
                    ifid_valid_d = 1'b1;
                    pc_d         = pc_q + XLEN'(4);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign imem_addr    = pc_q;
    assign imem_waddr   = ld_addr;
    assign imem_wdata   = ld_data;
    assign ifid_valid   = ifid_valid_q;
    assign ifid_pc      = ifid_pc_q;
    assign ifid_ir      = ifid_ir_q;
    assign err_misalign = err_mis_q;
    assign err_oob      = err_oob_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios plus a randomized run against a
// behavioural fetch model backed by a word-array IMEM.
module tb_imem_fetch_ctrl;
    import imem_fetch_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, halt = 1'b0, stall = 1'b0, redirect_en = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_rd, imem_we, ld_ready, ifid_valid, err_misalign, err_oob;
    logic [31:0] imem_addr, imem_rdata, imem_waddr, imem_wdata;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_addr = '0, ld_data = '0;
    logic [31:0] ifid_pc, ifid_ir;
    fetch_state_t dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem [0:127];
    logic [31:0] model_mem [0:127];
    logic [31:0] exp_q [$];

    imem_fetch_ctrl #(.XLEN(32), .IMEM_DEPTH(128), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .stall(stall),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
        .ifid_valid(ifid_valid), .ifid_pc(ifid_pc), .ifid_ir(ifid_ir),
        .err_misalign(err_misalign), .err_oob(err_oob), .dbg_state(dbg_state)
    );

    // clock / memory
    always #5 clk = ~clk;

    always @(posedge clk) if (imem_we) mem[imem_waddr[8:2]] <= imem_wdata;
    assign imem_rdata = (imem_addr < 32'h200) ? mem[imem_addr[8:2]] : 32'hDEAD_BEEF;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; start = 0; halt = 0; stall = 0; redirect_en = 0; ld_valid = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic do_start();
        halt = 1'b1; tick(); halt = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
    endtask

    // scenarios
    task automatic test_reset();
        n_tests++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL rst_state: got %0d expected %0d", dbg_state, ST_IDLE); end
        n_tests++; if (imem_rd !== 1'b0 || imem_we !== 1'b0) begin n_fail++; $display("FAIL rst_rd_we: got %b%b expected 00", imem_rd, imem_we); end
        n_tests++; if (ifid_valid !== 1'b0 || ifid_ir !== 32'h0 || ifid_pc !== 32'h0) begin n_fail++; $display("FAIL rst_ifid: got v=%b pc=%h ir=%h expected 0/0/0", ifid_valid, ifid_pc, ifid_ir); end
        n_tests++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h expected 0", imem_addr); end
        n_tests++; if (err_misalign !== 1'b0 || err_oob !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b%b expected 00", err_misalign, err_oob); end
        n_tests++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ld_ready: got %b expected 1", ld_ready); end
    endtask

    task automatic test_ld_oob();
        ld_valid = 1'b1; ld_addr = 32'h400; ld_data = $urandom; #1;
        n_tests++; if (ld_ready !== 1'b1 || imem_we !== 1'b0) begin n_fail++; $display("FAIL ld_oob_hs: got rdy=%b we=%b expected 1/0", ld_ready, imem_we); end
        tick(); ld_valid = 1'b0;
        n_tests++; if (err_oob !== 1'b1 || err_misalign !== 1'b0) begin n_fail++; $display("FAIL ld_oob_flag: got oob=%b mis=%b expected 1/0", err_oob, err_misalign); end
    endtask

    task automatic test_load();
        for (int i = 0; i < 128; i++) begin
            model_mem[i] = $urandom;
            ld_valid = 1'b1;
            ld_addr  = (i * 4) | $urandom_range(0, 3);
            ld_data  = model_mem[i];
            #1;
            n_tests++; if (imem_we !== 1'b1 || ld_ready !== 1'b1) begin n_fail++; $display("FAIL load_we[%0d]: got we=%b rdy=%b expected 1/1", i, imem_we, ld_ready); end
            n_tests++; if (imem_waddr !== ld_addr || imem_wdata !== model_mem[i]) begin n_fail++; $display("FAIL load_port[%0d]: got %h/%h expected %h/%h", i, imem_waddr, imem_wdata, ld_addr, model_mem[i]); end
            tick();
        end
        ld_valid = 1'b0;
        for (int i = 0; i < 128; i++) begin
            n_tests++; if (mem[i] !== model_mem[i]) begin n_fail++; $display("FAIL load_mem[%0d]: got %h expected %h", i, mem[i], model_mem[i]); end
        end
    endtask

    task automatic test_start_priority();
        start = 1'b1; ld_valid = 1'b1; ld_addr = 32'h0; ld_data = ~model_mem[0]; #1;
        n_tests++; if (ld_ready !== 1'b0 || imem_we !== 1'b0) begin n_fail++; $display("FAIL prio_hs: got rdy=%b we=%b expected 0/0", ld_ready, imem_we); end
        tick(); start = 1'b0; ld_valid = 1'b0;
        n_tests++; if (dbg_state !== ST_RUN || imem_rd !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL prio_run: got st=%0d rd=%b pc=%h expected RUN/1/0", dbg_state, imem_rd, imem_addr); end
        tick();
        n_tests++; if (ifid_ir !== model_mem[0]) begin n_fail++; $display("FAIL prio_word: got %h expected %h", ifid_ir, model_mem[0]); end
    endtask

    task automatic test_sequential();
        do_start();
        n_tests++; if (ifid_valid !== 1'b0 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL seq_entry: got v=%b pc=%h expected 0/0", ifid_valid, imem_addr); end
        for (int k = 0; k < 4; k++) exp_q.push_back(model_mem[k]);
        for (int k = 0; k < 4; k++) begin
            logic [31:0] w;
            tick();
            w = exp_q.pop_front();
            n_tests++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'(k * 4) || ifid_ir !== w) begin n_fail++; $display("FAIL seq[%0d]: got v=%b pc=%h ir=%h expected 1/%h/%h", k, ifid_valid, ifid_pc, ifid_ir, k * 4, w); end
        end
    endtask

    task automatic test_stall();
        do_start();
        tick(); tick();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++; if (ifid_pc !== 32'h4 || ifid_ir !== model_mem[1] || imem_addr !== 32'h8) begin n_fail++; $display("FAIL stall_hold[%0d]: got ipc=%h ir=%h pc=%h expected 4/%h/8", k, ifid_pc, ifid_ir, imem_addr, model_mem[1]); end
        end
        stall = 1'b0;
        tick();
        n_tests++; if (ifid_pc !== 32'h8 || ifid_ir !== model_mem[2]) begin n_fail++; $display("FAIL stall_resume8: got %h/%h expected 8/%h", ifid_pc, ifid_ir, model_mem[2]); end
        tick();
        n_tests++; if (ifid_pc !== 32'hC || ifid_ir !== model_mem[3]) begin n_fail++; $display("FAIL stall_resume12: got %h/%h expected c/%h", ifid_pc, ifid_ir, model_mem[3]); end
    endtask

    task automatic test_redirect();
        stall = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h40;
        tick();
        stall = 1'b0; redirect_en = 1'b0;
        n_tests++; if (ifid_valid !== 1'b0 || ifid_ir !== 32'h0 || imem_addr !== 32'h40) begin n_fail++; $display("FAIL redir_flush: got v=%b ir=%h pc=%h expected 0/0/40", ifid_valid, ifid_ir, imem_addr); end
        tick();
        n_tests++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h40 || ifid_ir !== model_mem[16]) begin n_fail++; $display("FAIL redir_fetch: got v=%b pc=%h ir=%h expected 1/40/%h", ifid_valid, ifid_pc, ifid_ir, model_mem[16]); end
    endtask

    task automatic test_misalign();
        redirect_en = 1'b1; redirect_pc = 32'h42;
        tick();
        redirect_en = 1'b0;
        n_tests++; if (dbg_state !== ST_HALT || imem_rd !== 1'b0 || ifid_valid !== 1'b0) begin n_fail++; $display("FAIL mis_halt: got st=%0d rd=%b v=%b expected HALT/0/0", dbg_state, imem_rd, ifid_valid); end
        n_tests++; if (err_misalign !== 1'b1 || err_oob !== 1'b0) begin n_fail++; $display("FAIL mis_flag: got mis=%b oob=%b expected 1/0", err_misalign, err_oob); end
    endtask

    task automatic test_oob();
        do_start();
        redirect_en = 1'b1; redirect_pc = 32'h1F8;
        tick(); redirect_en = 1'b0;
        tick(); tick();
        n_tests++; if (ifid_pc !== 32'h1FC || ifid_ir !== model_mem[127] || ifid_valid !== 1'b1) begin n_fail++; $display("FAIL oob_last: got v=%b pc=%h ir=%h expected 1/1fc/%h", ifid_valid, ifid_pc, ifid_ir, model_mem[127]); end
        n_tests++; if (imem_addr !== 32'h200 || imem_rd !== 1'b0) begin n_fail++; $display("FAIL oob_noissue: got pc=%h rd=%b expected 200/0", imem_addr, imem_rd); end
        tick();
        n_tests++; if (dbg_state !== ST_HALT || err_oob !== 1'b1 || ifid_valid !== 1'b0) begin n_fail++; $display("FAIL oob_halt: got st=%0d oob=%b v=%b expected HALT/1/0", dbg_state, err_oob, ifid_valid); end
    endtask

    task automatic test_reset_mid_run();
        do_start();
        tick(); tick();
        rst_n = 1'b0; #1;
        n_tests++; if (ifid_valid !== 1'b0 || ifid_pc !== 32'h0 || ifid_ir !== 32'h0) begin n_fail++; $display("FAIL midrst_ifid: got v=%b pc=%h ir=%h expected 0/0/0", ifid_valid, ifid_pc, ifid_ir); end
        n_tests++; if (imem_rd !== 1'b0 || imem_addr !== 32'h0 || dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL midrst_ctl: got rd=%b pc=%h st=%0d expected 0/0/IDLE", imem_rd, imem_addr, dbg_state); end
        n_tests++; if (err_oob !== 1'b0 || err_misalign !== 1'b0) begin n_fail++; $display("FAIL midrst_err: got %b%b expected 00", err_oob, err_misalign); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // behavioural model: mode 0 idle, 1 running, 2 halted
    task automatic test_random();
        int          m_mode = 0;
        logic [31:0] m_pc = 0, m_ipc = 0, m_ir = 0;
        logic        m_v = 0, m_mis = 0, m_oob = 0;
        apply_reset();
        for (int c = 0; c < 1500; c++) begin
            start = (m_mode != 1) && ($urandom_range(0, 3) == 0);
            halt  = ($urandom_range(0, 49) == 0);
            stall = ($urandom_range(0, 3) == 0);
            redirect_en = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 7))
                0:       redirect_pc = 32'h200 + 4 * $urandom_range(0, 3);
                1:       redirect_pc = 4 * $urandom_range(0, 127) + $urandom_range(1, 3);
                default: redirect_pc = 4 * $urandom_range(0, 127);
            endcase
            #1;
            n_tests++; if (imem_rd !== (m_mode == 1 && m_pc < 32'h200) || imem_addr !== m_pc) begin n_fail++; $display("FAIL rnd_comb[%0d]: got rd=%b pc=%h expected %b/%h", c, imem_rd, imem_addr, (m_mode == 1 && m_pc < 32'h200), m_pc); end
            if (m_mode != 1) begin
                if (start) begin m_mode = 1; m_pc = 0; end
            end else if (halt) begin
                m_mode = 2; m_v = 0;
            end else if (redirect_en && redirect_pc % 4 == 0) begin
                m_pc = redirect_pc; m_v = 0;
            end else if (redirect_en) begin
                m_mode = 2; m_mis = 1; m_v = 0;
            end else if (m_pc >= 32'h200) begin
                m_mode = 2; m_oob = 1; m_v = 0;
            end else if (!stall) begin
                m_v = 1; m_ipc = m_pc; m_ir = model_mem[m_pc / 4]; m_pc = m_pc + 4;
            end
            tick();
            start = 0; halt = 0; stall = 0; redirect_en = 0;
            n_tests++; if (ifid_valid !== m_v || ifid_ir !== (m_v ? m_ir : 32'h0) || (m_v && ifid_pc !== m_ipc)) begin n_fail++; $display("FAIL rnd_ifid[%0d]: got v=%b pc=%h ir=%h expected %b/%h/%h", c, ifid_valid, ifid_pc, ifid_ir, m_v, m_ipc, m_v ? m_ir : 32'h0); end
            n_tests++; if (err_misalign !== m_mis || err_oob !== m_oob) begin n_fail++; $display("FAIL rnd_err[%0d]: got mis=%b oob=%b expected %b/%b", c, err_misalign, err_oob, m_mis, m_oob); end
        end
    endtask

    initial begin
        apply_reset();
        test_reset();
        test_ld_oob();
        apply_reset();
        test_load();
        test_start_priority();
        test_sequential();
        test_stall();
        test_redirect();
        test_misalign();
        test_oob();
        test_reset_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
